// File: rtl/wm_pkg.sv
// Shared state encoding and actuator decode for the wash sequencer.
// The decode is pure combinational; only FAULT also looks at a sensor input (for the door lock).
package wm_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    FILL  = 4'd1,
    WASH  = 4'd2,
    DRAIN = 4'd3,
    RFILL = 4'd4,
    RINSE = 4'd5,
    SPIN  = 4'd6,
    DONE  = 4'd7,
    FAULT = 4'd8
  } wm_state_e;

  typedef struct packed {
    logic door_locked;
    logic motor_active;
    logic fill_valve_open;
    logic drain_valve_open;
    logic detergent_cycle;
    logic rinse_cycle;
    logic operation_done;
    logic fault;
  } wm_out_t;

  // Pause gates only the water/motor actuators; lock and stage flags keep their decode.
  function automatic wm_out_t wm_decode(input wm_state_e st, input logic paused,
                                        input logic drained);
    wm_out_t o;
    o = '0;
    case (st)
      FILL: begin
        o.door_locked     = 1'b1;
        o.fill_valve_open = !paused;
      end
      WASH: begin
        o.door_locked     = 1'b1;
        o.motor_active    = !paused;
        o.detergent_cycle = 1'b1;
      end
      DRAIN: begin
        o.door_locked      = 1'b1;
        o.drain_valve_open = !paused;
      end
      RFILL: begin
        o.door_locked     = 1'b1;
        o.fill_valve_open = !paused;
        o.rinse_cycle     = 1'b1;
      end
      RINSE: begin
        o.door_locked  = 1'b1;
        o.motor_active = !paused;
        o.rinse_cycle  = 1'b1;
      end
      SPIN: begin
        o.door_locked      = 1'b1;
        o.motor_active     = !paused;
        o.drain_valve_open = !paused;
      end
      DONE: o.operation_done = 1'b1;
      FAULT: begin
        o.fault            = 1'b1;
        o.drain_valve_open = 1'b1;
        o.door_locked      = !drained;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/wash_sequencer_param_if.sv
// Sensor/button inputs and actuator/status outputs of the wash sequencer.
// master = front-end driving sensors; slave = the controller.
interface wash_sequencer_param_if #(
  parameter int RC_W = 4
);
  logic            start_button;
  logic            door_closed;
  logic            pause_button;
  logic            water_filled;
  logic            detergent_added;
  logic            cycle_complete;
  logic            water_drained;
  logic            spin_complete;
  logic            door_locked;
  logic            motor_active;
  logic            fill_valve_open;
  logic            drain_valve_open;
  logic            detergent_cycle;
  logic            rinse_cycle;
  logic            operation_done;
  logic            fault;
  logic [RC_W-1:0] rinse_count;
  logic [3:0]      state;

  modport master (
    output start_button, door_closed, pause_button, water_filled,
           detergent_added, cycle_complete, water_drained, spin_complete,
    input  door_locked, motor_active, fill_valve_open, drain_valve_open,
           detergent_cycle, rinse_cycle, operation_done, fault, rinse_count, state
  );

  modport slave (
    input  start_button, door_closed, pause_button, water_filled,
           detergent_added, cycle_complete, water_drained, spin_complete,
    output door_locked, motor_active, fill_valve_open, drain_valve_open,
           detergent_cycle, rinse_cycle, operation_done, fault, rinse_count, state
  );
endinterface

// File: rtl/wm_stage_timer.sv
// Per-stage watchdog counter: clear wins over enable; expired flags the last allowed cycle.
// Latency: expired is a decode of the registered count; no backpressure.
module wm_stage_timer #(
  parameter int TMR_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A zero timeout disables the watchdog entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/wash_sequencer_param.sv
// Wash-cycle controller: fill/wash/drain/N rinses/spin with pause, per-stage watchdog, latched fault.
// Latency: Moore outputs one edge after the deciding inputs; no backpressure (level sensors).
module wash_sequencer_param
  import wm_pkg::*;
#(
  parameter int NUM_RINSES     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 16,
  parameter int RC_W           = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  wash_sequencer_param_if.slave        io
);

  localparam logic [RC_W-1:0] RC_MAX = RC_W'(NUM_RINSES);

  wm_state_e       state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic            paused_q, paused_d;
  logic            exit_ok;
  wm_state_e       exit_to;
  logic            rinse_more;
  logic            tmr_clear, tmr_en, tmr_expired;
  wm_out_t         outs;

  // rinse_count never exceeds NUM_RINSES, so inequality is the "more rinses due" test.
  assign rinse_more = (NUM_RINSES != 0) && (rc_q != RC_MAX);

  always_comb begin
    exit_ok = 1'b0;
    exit_to = state_q;
    case (state_q)
      FILL: begin
        exit_ok = io.water_filled;
        exit_to = WASH;
      end
      WASH: begin
        exit_ok = io.detergent_added & io.cycle_complete;
        exit_to = DRAIN;
      end
      DRAIN: begin
        exit_ok = io.water_drained;
        exit_to = rinse_more ? RFILL : SPIN;
      end
      RFILL: begin
        exit_ok = io.water_filled;
        exit_to = RINSE;
      end
      RINSE: begin
        exit_ok = io.cycle_complete;
        exit_to = DRAIN;
      end
      SPIN: begin
        exit_ok = io.spin_complete;
        exit_to = DONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rc_d     = rc_q;
    paused_d = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start_button && io.door_closed) begin
          state_d = FILL;
          rc_d    = '0;
        end
      end
      DONE: begin
        if (!io.door_closed) state_d = IDLE;
      end
      FILL, WASH, DRAIN, RFILL, RINSE, SPIN: begin
        // Door and watchdog outrank pause; pause outranks the normal exit.
        if (!io.door_closed) begin
          state_d = FAULT;
        end else if (tmr_expired && !exit_ok) begin
          state_d = FAULT;
        end else if (io.pause_button) begin
          paused_d = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (exit_ok) begin
            state_d = exit_to;
            if (state_q == RINSE && rc_q != RC_MAX) rc_d = rc_q + 1'b1;
          end
        end
      end
      default: state_d = FAULT;
    endcase
  end

  assign tmr_clear = (state_d != state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rc_q     <= '0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rc_q     <= rc_d;
      paused_q <= paused_d;
    end
  end

  wm_stage_timer #(
    .TMR_W          (TMR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  assign outs = wm_decode(state_q, paused_q, io.water_drained);

  assign io.door_locked      = outs.door_locked;
  assign io.motor_active     = outs.motor_active;
  assign io.fill_valve_open  = outs.fill_valve_open;
  assign io.drain_valve_open = outs.drain_valve_open;
  assign io.detergent_cycle  = outs.detergent_cycle;
  assign io.rinse_cycle      = outs.rinse_cycle;
  assign io.operation_done   = outs.operation_done;
  assign io.fault            = outs.fault;
  assign io.rinse_count      = rc_q;
  assign io.state            = state_q;

endmodule

// File: tb/tb_wash_sequencer_param.sv
// Bench: two sequencers (2 rinses / 8-cycle watchdog, and 0 rinses / no watchdog) driven in lockstep
// against a stage-level reference model, plus a path table and hand-written corner sequences.
module tb_wash_sequencer_param;

  localparam logic [7:0] I_START = 8'h80, I_DOOR = 8'h40, I_PAUSE = 8'h20, I_WF = 8'h10;
  localparam logic [7:0] I_DET = 8'h08, I_CC = 8'h04, I_WD = 8'h02, I_SC = 8'h01;
  localparam int NR [2] = '{2, 0};
  localparam int TO [2] = '{8, 0};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wash_sequencer_param_if #(.RC_W(4)) ifa ();
  wash_sequencer_param_if #(.RC_W(4)) ifb ();

  wash_sequencer_param #(.NUM_RINSES(2), .TIMEOUT_CYCLES(8), .TMR_W(16), .RC_W(4)) dut_a (
    .clk(clk), .reset(reset), .io(ifa));
  wash_sequencer_param #(.NUM_RINSES(0), .TIMEOUT_CYCLES(0), .TMR_W(16), .RC_W(4)) dut_b (
    .clk(clk), .reset(reset), .io(ifb));

  int total = 0;
  int bad = 0;
  int m_st [2];
  int m_rc [2];
  int m_tmr [2];
  bit m_psd [2];
  bit b_rinse_seen = 1'b0;

  typedef struct {
    logic [7:0] in;
    int         st_a;
    int         rc_a;
    int         st_b;
    logic       done_a;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] act_a();
    return {ifa.state, ifa.rinse_count, ifa.door_locked, ifa.motor_active, ifa.fill_valve_open,
            ifa.drain_valve_open, ifa.detergent_cycle, ifa.rinse_cycle, ifa.operation_done, ifa.fault};
  endfunction

  function automatic logic [15:0] act_b();
    return {ifb.state, ifb.rinse_count, ifb.door_locked, ifb.motor_active, ifb.fill_valve_open,
            ifb.drain_valve_open, ifb.detergent_cycle, ifb.rinse_cycle, ifb.operation_done, ifb.fault};
  endfunction

  // Expected {state, rinse_count, lock, motor, fill, drain, det, rinse, done, fault}.
  function automatic logic [15:0] mexp(input int i, input logic wd);
    logic [7:0] o;
    logic run;
    run = !m_psd[i];
    case (m_st[i])
      1: o = {1'b1, 1'b0, run, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      2: o = {1'b1, run, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      3: o = {1'b1, 1'b0, 1'b0, run, 1'b0, 1'b0, 1'b0, 1'b0};
      4: o = {1'b1, 1'b0, run, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      5: o = {1'b1, run, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      6: o = {1'b1, run, 1'b0, run, 1'b0, 1'b0, 1'b0, 1'b0};
      7: o = 8'b0000_0010;
      8: o = {!wd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      default: o = 8'h00;
    endcase
    return {4'(m_st[i]), 4'(m_rc[i]), o};
  endfunction

  task automatic mgo(input int i, input int nxt);
    m_st[i] = nxt;
    m_tmr[i] = 0;
    m_psd[i] = 1'b0;
  endtask

  task automatic mstep(input int i, input logic [7:0] v, input logic rst);
    bit start, door, pause, wf, det, cc, wd, sc, ex;
    int to;
    {start, door, pause, wf, det, cc, wd, sc} = v;
    ex = 1'b0;
    to = 0;
    if (rst) begin
      mgo(i, 0);
      m_rc[i] = 0;
    end else if (m_st[i] == 0) begin
      if (start && door) begin
        mgo(i, 1);
        m_rc[i] = 0;
      end
    end else if (m_st[i] == 7) begin
      if (!door) mgo(i, 0);
    end else if (m_st[i] != 8) begin
      case (m_st[i])
        1: begin ex = wf; to = 2; end
        2: begin ex = det && cc; to = 3; end
        3: begin ex = wd; to = (m_rc[i] < NR[i]) ? 4 : 6; end
        4: begin ex = wf; to = 5; end
        5: begin ex = cc; to = 3; end
        default: begin ex = sc; to = 7; end
      endcase
      if (!door) mgo(i, 8);
      else if (TO[i] > 0 && m_tmr[i] == TO[i] - 1 && !ex) mgo(i, 8);
      else if (pause) m_psd[i] = 1'b1;
      else begin
        m_psd[i] = 1'b0;
        if (ex) begin
          if (m_st[i] == 5 && m_rc[i] < NR[i]) m_rc[i]++;
          mgo(i, to);
        end else begin
          m_tmr[i]++;
        end
      end
    end
  endtask

  task automatic step(input logic [7:0] v, input logic rst);
    {ifa.start_button, ifa.door_closed, ifa.pause_button, ifa.water_filled,
     ifa.detergent_added, ifa.cycle_complete, ifa.water_drained, ifa.spin_complete} = v;
    {ifb.start_button, ifb.door_closed, ifb.pause_button, ifb.water_filled,
     ifb.detergent_added, ifb.cycle_complete, ifb.water_drained, ifb.spin_complete} = v;
    reset = rst;
    mstep(0, v, rst);
    mstep(1, v, rst);
    @(posedge clk);
    #1;
    chk("model_a", act_a(), mexp(0, v[1]));
    chk("model_b", act_b(), mexp(1, v[1]));
    if (ifb.rinse_cycle === 1'b1) b_rinse_seen = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{I_START | I_DOOR, 1, 0, 1, 1'b0};
    tbl[1]  = '{I_DOOR | I_WF,    2, 0, 2, 1'b0};
    tbl[2]  = '{I_DOOR | I_DET | I_CC, 3, 0, 3, 1'b0};
    tbl[3]  = '{I_DOOR | I_WD,    4, 0, 6, 1'b0};
    tbl[4]  = '{I_DOOR | I_WF,    5, 0, 6, 1'b0};
    tbl[5]  = '{I_DOOR | I_CC,    3, 1, 6, 1'b0};
    tbl[6]  = '{I_DOOR | I_WD,    4, 1, 6, 1'b0};
    tbl[7]  = '{I_DOOR | I_WF,    5, 1, 6, 1'b0};
    tbl[8]  = '{I_DOOR | I_CC,    3, 2, 6, 1'b0};
    tbl[9]  = '{I_DOOR | I_WD,    6, 2, 6, 1'b0};
    tbl[10] = '{I_DOOR | I_SC,    7, 2, 7, 1'b1};
    tbl[11] = '{8'h00,            0, 2, 0, 1'b0};
    tbl[12] = '{I_DOOR,           0, 2, 0, 1'b0};

    // Reset state
    step(8'h00, 1'b1);
    step(I_DOOR, 1'b1);
    chk("reset_a", act_a(), 16'h0000);
    chk("reset_b", act_b(), 16'h0000);

    // Full path, both rinse configurations
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].in, 1'b0);
      chk("tbl_state_a", 16'(ifa.state), 16'(tbl[i].st_a));
      chk("tbl_rc_a", 16'(ifa.rinse_count), 16'(tbl[i].rc_a));
      chk("tbl_state_b", 16'(ifb.state), 16'(tbl[i].st_b));
      chk("tbl_done_a", 16'(ifa.operation_done), 16'(tbl[i].done_a));
    end

    // Watchdog: FILL with no water faults 8 edges after entry
    step(I_START | I_DOOR, 1'b0);
    for (int k = 0; k < 7; k++) step(I_DOOR, 1'b0);
    chk("wd_still_fill", 16'(ifa.state), 16'd1);
    step(I_DOOR, 1'b0);
    chk("wd_fault_state", 16'(ifa.state), 16'd8);
    chk("wd_fault_outs", {12'h0, ifa.fault, ifa.drain_valve_open, ifa.fill_valve_open, ifa.door_locked},
        16'b1101);
    chk("wd_b_no_fault", 16'(ifb.state), 16'd1);
    step(I_DOOR | I_WD, 1'b0);
    chk("wd_lock_drop", 16'(ifa.door_locked), 16'd0);
    step(8'h00, 1'b1);

    // Door opened for one cycle in WASH
    step(I_START | I_DOOR, 1'b0);
    step(I_DOOR | I_WF, 1'b0);
    step(I_DOOR, 1'b0);
    step(8'h00, 1'b0);
    chk("door_fault_a", 16'(ifa.state), 16'd8);
    chk("door_fault_b", 16'(ifb.state), 16'd8);
    for (int k = 0; k < 3; k++) begin
      step(I_START | I_DOOR | I_WF | I_DET | I_CC | I_WD | I_SC, 1'b0);
      chk("fault_latched", 16'(ifa.fault), 16'd1);
    end
    step(8'h00, 1'b1);

    // Pause 20 cycles in RINSE; timer resumes from its frozen value
    for (int i = 0; i < 5; i++) step(tbl[i].in, 1'b0);
    for (int k = 0; k < 3; k++) step(I_DOOR, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(I_DOOR | I_PAUSE, 1'b0);
      chk("pause_hold", {12'h0, ifa.state}, 16'd5);
      chk("pause_outs", {13'h0, ifa.motor_active, ifa.door_locked, ifa.rinse_cycle}, 16'b011);
    end
    step(I_DOOR, 1'b0);
    chk("release_motor", 16'(ifa.motor_active), 16'd1);
    for (int k = 0; k < 3; k++) step(I_DOOR, 1'b0);
    chk("resume_rinse", 16'(ifa.state), 16'd5);
    step(I_DOOR, 1'b0);
    chk("resume_expire", 16'(ifa.state), 16'd8);
    step(8'h00, 1'b1);

    // Reset mid-SPIN
    for (int i = 0; i < 10; i++) step(tbl[i].in, 1'b0);
    step(I_DOOR, 1'b0);
    chk("in_spin", 16'(ifa.state), 16'd6);
    step(I_DOOR, 1'b1);
    chk("spin_reset", act_a(), 16'h0000);

    // Randomised traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] v;
      v = {($urandom_range(3) == 0), ($urandom_range(40) != 0), ($urandom_range(9) == 0),
           ($urandom_range(2) == 0), ($urandom_range(2) == 0), ($urandom_range(2) == 0),
           ($urandom_range(2) == 0), ($urandom_range(2) == 0)};
      step(v, ($urandom_range(149) == 0));
    end

    chk("b_never_rinse", 16'(b_rinse_seen), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
